dma_cfg_ctrl: RTL and testbench
===============================

Name: dma_cfg_ctrl

Overview:
- Software-facing command front-end for the DMA engine; it drives the DMA's start/length/address inputs and consumes its valid/done handshake.
- A CPU programs transfers through a simple word-addressed register bus.
- An FSM launches the DMA and tracks its progress bits (load, store, done), retires the transfer with a done pulse/hold, and records PMP-denial and timeout status.
- It sits between the core's peripheral register bus and the DMA block, one instance per DMA.

Parameters:
- DATA_WIDTH, 32, width of register bus and all DMA command fields.
- TO_WIDTH, 16, width of the timeout counter and TIMEOUT register field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset; one clock, all state sampled on rising edge
- req_i  in  1  register access request
- we_i  in  1  1=write, 0=read
- addr_i  in  3  word index of register
- wdata_i  in  DATA_WIDTH  write data
- rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o
- rvalid_o  out  1  access completion, exactly 1 cycle after req_i
- start_o  out  DATA_WIDTH  to DMA start_i; value 1 while launching, else 0
- length_o  out  DATA_WIDTH  to DMA length_i
- src_lsb_o / src_msb_o  out  DATA_WIDTH each  to DMA source address inputs
- dst_lsb_o / dst_msb_o  out  DATA_WIDTH each  to DMA destination address inputs
- valid_i  in  DATA_WIDTH  from DMA valid_o: bit1=load done, bit2=store done, bit3=done
- done_o  out  DATA_WIDTH  to DMA done_i; value 1 during ACK, else 0
- irq_o  out  1  completion interrupt (optional feature)

Behaviour:
- Register map (addr_i):
  - 0 CTRL: bit0 GO, write-1 only, self-clearing, reads 0; bit1 IRQ_EN.
  - 1 LENGTH.
  - 2 SRC_LSB.
  - 3 SRC_MSB.
  - 4 DST_LSB.
  - 5 DST_MSB.
  - 6 STATUS: bit0 BUSY (RO); bits 1-6 are write-1-to-clear: bit1 LOAD_OK, bit2 STORE_OK, bit3 DONE, bit4 DENIED, bit5 TIMEOUT, bit6 WR_ERR.
  - 7 TIMEOUT: [TO_WIDTH-1:0], 0 = disabled.
- Bus access:
  - Every req_i gets rvalid_o=1 on the next cycle; rdata_o carries the read value, 0 for writes.
  - No back-pressure.
- Command shadow:
  - length/src/dst outputs are driven directly from their registers.
  - Writes to regs 1-5 or GO while BUSY are dropped and set WR_ERR.
  - Outputs stay stable for the whole transfer.
- FSM states: IDLE, LAUNCH, WAIT, ACK.
  - IDLE: start_o=0, done_o=0. Write with GO=1 -> LAUNCH next cycle. In the same cycle, STATUS bits 1-5 clear and the timeout counter loads 0.
  - LAUNCH: start_o=1, BUSY=1. Stays until valid_i[3]=1 -> ACK. Timeout counter increments each cycle in LAUNCH and WAIT.
  - WAIT: entered from LAUNCH when valid_i[1] first seen; start_o=0. Exits to ACK on valid_i[3]=1.
  - Timeout: when TIMEOUT!=0 and counter==TIMEOUT in LAUNCH/WAIT, set TIMEOUT status, -> ACK.
  - ACK: start_o=0, done_o=1. When valid_i==0 -> IDLE, done_o=0, DONE=1, BUSY=0.
- Status latching: LOAD_OK/STORE_OK are sticky ORs of valid_i[1]/valid_i[2] while BUSY. On the cycle valid_i[3] is first seen, DENIED = !valid_i[2].
- Simultaneous events: GO together with a STATUS W1C in one access is impossible (different addresses). A timeout and valid_i[3] in the same cycle: take ACK, and set TIMEOUT only if valid_i[3]=0.
- Counter saturates at all-ones; no wrap.
- Reset: all registers 0; state IDLE; every output 0, including rvalid_o and irq_o. Reset mid-transfer returns to IDLE immediately and drops start_o/done_o.

Optional Feature:
- DMA_CFG_IRQ_EN defined:
  - irq_o = IRQ_EN & (DONE | TIMEOUT), as a level.
  - It clears when software W1Cs the causing bits.
- DMA_CFG_IRQ_EN undefined:
  - irq_o tied 0.
  - CTRL bit1 is not stored and reads 0.

Test Plan:
- Reset, then read all 8 regs -> all read 0, rvalid_o 1 cycle after each req_i, start_o=done_o=0.
- Program LENGTH=3, SRC=0x8000_0000, DST=0x8000_1000, GO=1; model DMA returns valid_i=2,6,14 -> start_o=1 until valid_i[1], done_o=1 held until valid_i=0, then STATUS=0x0E.
- PMP denial: after GO, model returns valid_i=8 directly -> ACK entered, STATUS reads 0x18 (DONE|DENIED), STORE_OK=0.
- TIMEOUT=5, GO, valid_i held 0 -> ACK after 5 cycles in LAUNCH, then STATUS reads 0x28.
- While BUSY, write LENGTH=9 and GO -> length_o unchanged at 3, WR_ERR set; W1C 0x40 clears it.
- With DMA_CFG_IRQ_EN: CTRL=0x2, complete a transfer -> irq_o=1; W1C 0x08 -> irq_o=0. Without the macro, irq_o stays 0.

Source files
------------

// File: rtl/dma_cfg_ctrl.sv
// dma_cfg_ctrl: register-bus front-end that programs, launches and retires DMA transfers.
// Optional level completion interrupt is built when DMA_CFG_IRQ_EN is defined.
module dma_cfg_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TO_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] start_o,
  output logic [DATA_WIDTH-1:0] length_o,
  output logic [DATA_WIDTH-1:0] src_lsb_o,
  output logic [DATA_WIDTH-1:0] src_msb_o,
  output logic [DATA_WIDTH-1:0] dst_lsb_o,
  output logic [DATA_WIDTH-1:0] dst_msb_o,
  input  logic [DATA_WIDTH-1:0] valid_i,
  output logic [DATA_WIDTH-1:0] done_o,
  output logic                  irq_o
);

  localparam logic [DATA_WIDTH-1:0] ZERO    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0]   TO_ZERO = {TO_WIDTH{1'b0}};
  localparam logic [TO_WIDTH-1:0]   TO_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0]   TO_MAX  = {TO_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t                state_r;
  logic                  start_r;
  logic                  done_r;
  logic [TO_WIDTH-1:0]   cnt_r;
  logic [TO_WIDTH-1:0]   timeout_r;
  logic [DATA_WIDTH-1:0] length_r;
  logic [DATA_WIDTH-1:0] src_lsb_r;
  logic [DATA_WIDTH-1:0] src_msb_r;
  logic [DATA_WIDTH-1:0] dst_lsb_r;
  logic [DATA_WIDTH-1:0] dst_msb_r;
  // sts_r[1]=LOAD_OK [2]=STORE_OK [3]=DONE [4]=DENIED [5]=TIMEOUT [6]=WR_ERR
  logic [6:1]            sts_r;
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic                  busy_s;
  logic                  xfer_s;
  logic                  wr_s;
  logic                  go_s;
  logic                  cmd_wr_s;
  logic                  drop_s;
  logic                  launch_s;
  logic                  w1c_s;
  logic                  to_hit_s;
  logic                  irq_en_s;
  logic [6:1]            w1c_mask_s;
  logic [6:1]            sts_set_s;
  logic [DATA_WIDTH-1:0] rd_s;

  assign busy_s     = (state_r != ST_IDLE);
  assign xfer_s     = (state_r == ST_LAUNCH) || (state_r == ST_WAIT);
  assign wr_s       = req_i & we_i;
  assign go_s       = wr_s && (addr_i == 3'd0) && wdata_i[0];
  assign cmd_wr_s   = wr_s && (addr_i >= 3'd1) && (addr_i <= 3'd5);
  assign drop_s     = busy_s && (go_s || cmd_wr_s);
  assign launch_s   = go_s && !busy_s;
  assign w1c_s      = wr_s && (addr_i == 3'd6);
  assign w1c_mask_s = w1c_s ? wdata_i[6:1] : 6'b000000;
  assign to_hit_s   = (timeout_r != TO_ZERO) && (cnt_r == timeout_r);

  assign start_o   = start_r ? ONE : ZERO;
  assign done_o    = done_r ? ONE : ZERO;
  assign length_o  = length_r;
  assign src_lsb_o = src_lsb_r;
  assign src_msb_o = src_msb_r;
  assign dst_lsb_o = dst_lsb_r;
  assign dst_msb_o = dst_msb_r;
  assign rdata_o   = rdata_r;
  assign rvalid_o  = rvalid_r;

`ifdef DMA_CFG_IRQ_EN
  logic irq_en_r;

  // IRQ_EN follows any accepted CTRL write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_r <= 1'b0;
    end else if (wr_s && (addr_i == 3'd0) && !drop_s) begin
      irq_en_r <= wdata_i[1];
    end else begin
      irq_en_r <= irq_en_r;
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq_o    = irq_en_r & (sts_r[3] | sts_r[5]);
`else
  assign irq_en_s = 1'b0;
  assign irq_o    = 1'b0;
`endif

  // Transfer sequencing: launch, wait for DMA progress, hold done until valid_i drops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      start_r <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= TO_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (launch_s) begin
            state_r <= ST_LAUNCH;
            start_r <= 1'b1;
            cnt_r   <= TO_ZERO;
          end else begin
            state_r <= ST_IDLE;
            start_r <= 1'b0;
          end
        end
        ST_LAUNCH, ST_WAIT: begin
          cnt_r <= (cnt_r == TO_MAX) ? cnt_r : cnt_r + TO_ONE;
          if (valid_i[3] || to_hit_s) begin
            state_r <= ST_ACK;
            start_r <= 1'b0;
            done_r  <= 1'b1;
          end else if (valid_i[1]) begin
            state_r <= ST_WAIT;
            start_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_ACK: begin
          if (valid_i == ZERO) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_ACK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          start_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Status bits raised by hardware this cycle; a timeout loses to a same-cycle done
  always_comb begin
    sts_set_s    = 6'b000000;
    sts_set_s[6] = drop_s;
    if (busy_s) begin
      sts_set_s[1] = valid_i[1];
      sts_set_s[2] = valid_i[2];
    end else begin
      sts_set_s[2:1] = 2'b00;
    end
    if (xfer_s && valid_i[3]) begin
      sts_set_s[4] = ~valid_i[2];
    end else if (xfer_s && to_hit_s) begin
      sts_set_s[5] = 1'b1;
    end else if ((state_r == ST_ACK) && (valid_i == ZERO)) begin
      sts_set_s[3] = 1'b1;
    end else begin
      sts_set_s[5:3] = 3'b000;
    end
  end

  // STATUS register: launch clears transfer bits, W1C clears, hardware sets win
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sts_r <= 6'b000000;
    end else if (launch_s) begin
      sts_r <= {sts_r[6], 5'b00000};
    end else begin
      sts_r <= (sts_r & ~w1c_mask_s) | sts_set_s;
    end
  end

  // Command shadow registers, frozen while a transfer is in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      length_r  <= ZERO;
      src_lsb_r <= ZERO;
      src_msb_r <= ZERO;
      dst_lsb_r <= ZERO;
      dst_msb_r <= ZERO;
      timeout_r <= TO_ZERO;
    end else begin
      if (cmd_wr_s && !busy_s) begin
        case (addr_i)
          3'd1:    length_r  <= wdata_i;
          3'd2:    src_lsb_r <= wdata_i;
          3'd3:    src_msb_r <= wdata_i;
          3'd4:    dst_lsb_r <= wdata_i;
          3'd5:    dst_msb_r <= wdata_i;
          default: length_r  <= length_r;
        endcase
      end
      if (wr_s && (addr_i == 3'd7)) begin
        timeout_r <= wdata_i[TO_WIDTH-1:0];
      end
    end
  end

  // Register read mux
  always_comb begin
    rd_s = ZERO;
    case (addr_i)
      3'd0:    rd_s[1]            = irq_en_s;
      3'd1:    rd_s               = length_r;
      3'd2:    rd_s               = src_lsb_r;
      3'd3:    rd_s               = src_msb_r;
      3'd4:    rd_s               = dst_lsb_r;
      3'd5:    rd_s               = dst_msb_r;
      3'd6:    rd_s[6:0]          = {sts_r, busy_s};
      3'd7:    rd_s[TO_WIDTH-1:0] = timeout_r;
      default: rd_s               = ZERO;
    endcase
  end

  // Single-cycle bus response; writes return zero data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      rdata_r  <= ZERO;
    end else begin
      rvalid_r <= req_i;
      rdata_r  <= (req_i && !we_i) ? rd_s : ZERO;
    end
  end

endmodule

// File: tb/tb_dma_cfg_ctrl.sv
// Bench for dma_cfg_ctrl: directed register/DMA-handshake sequences checked against a
// transaction-level model every cycle, plus hand-computed literal expectations.
module tb_dma_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i, valid_i;
  logic [31:0] rdata_o, start_o, length_o, src_lsb_o, src_msb_o, dst_lsb_o, dst_msb_o, done_o;
  logic        rvalid_o, irq_o;

  always #5 clk = ~clk;

  dma_cfg_ctrl #(.DATA_WIDTH(32), .TO_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .start_o(start_o),
    .length_o(length_o), .src_lsb_o(src_lsb_o), .src_msb_o(src_msb_o),
    .dst_lsb_o(dst_lsb_o), .dst_msb_o(dst_msb_o), .valid_i(valid_i),
    .done_o(done_o), .irq_o(irq_o)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

`ifdef DMA_CFG_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  // Transaction-level model of the register file and the transfer in flight
  bit          model_ok = 1'b0;
  logic [31:0] m_reg [0:7];
  int          m_tmo, m_elapsed;
  bit [6:1]    m_sts;
  bit          m_xfer, m_start, m_done, m_irq_en, m_rvalid, m_was;
  logic [31:0] m_rdata, m_rd;

  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
      m_tmo = 0; m_elapsed = 0; m_sts = 6'd0;
      m_xfer = 1'b0; m_start = 1'b0; m_done = 1'b0; m_irq_en = 1'b0;
      m_rvalid = 1'b0; m_rdata = 32'd0;
      model_ok = 1'b1;
    end else begin
      m_was = m_xfer;
      m_rd = 32'd0;
      case (addr_i)
        3'd0: m_rd[1] = m_irq_en;
        3'd6: m_rd = {25'd0, m_sts, m_was};
        3'd7: m_rd = m_tmo;
        default: m_rd = m_reg[addr_i];
      endcase
      m_rvalid = req_i;
      m_rdata = (req_i && !we_i) ? m_rd : 32'd0;
      if (req_i && we_i) begin
        if (addr_i == 3'd0) begin
          if (wdata_i[0] && m_was) m_sts[6] = 1'b1;
          else begin
            if (IRQ_BUILT) m_irq_en = wdata_i[1];
            if (wdata_i[0]) begin
              m_xfer = 1'b1; m_start = 1'b1; m_done = 1'b0;
              m_elapsed = 0; m_sts[5:1] = 5'd0;
            end
          end
        end else if (addr_i <= 3'd5) begin
          if (m_was) m_sts[6] = 1'b1;
          else m_reg[addr_i] = wdata_i;
        end else if (addr_i == 3'd6) begin
          m_sts = m_sts & ~wdata_i[6:1];
        end else begin
          m_tmo = int'(wdata_i[15:0]);
        end
      end
      if (m_was) begin
        if (valid_i[1]) m_sts[1] = 1'b1;
        if (valid_i[2]) m_sts[2] = 1'b1;
        if (!m_done) begin
          if (valid_i[3]) begin
            m_done = 1'b1; m_start = 1'b0; m_sts[4] = !valid_i[2];
          end else if (m_tmo != 0 && m_elapsed == m_tmo) begin
            m_done = 1'b1; m_start = 1'b0; m_sts[5] = 1'b1;
          end else if (valid_i[1]) begin
            m_start = 1'b0;
          end
          if (m_elapsed < 65535) m_elapsed++;
        end else if (valid_i == 32'd0) begin
          m_done = 1'b0; m_xfer = 1'b0; m_sts[3] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (model_ok) begin
      check("start_o", start_o, {31'd0, m_start});
      check("done_o", done_o, {31'd0, m_done});
      check("length_o", length_o, m_reg[1]);
      check("src_lsb_o", src_lsb_o, m_reg[2]);
      check("src_msb_o", src_msb_o, m_reg[3]);
      check("dst_lsb_o", dst_lsb_o, m_reg[4]);
      check("dst_msb_o", dst_msb_o, m_reg[5]);
      check("rvalid_o", {31'd0, rvalid_o}, {31'd0, m_rvalid});
      check("rdata_o", rdata_o, m_rdata);
      check("irq_o", {31'd0, irq_o}, {31'd0, m_irq_en & (m_sts[3] | m_sts[5])});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    cyc();
    req_i = 1'b0; we_i = 1'b0; addr_i = 3'd0; wdata_i = 32'd0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus(1'b0, a, 32'd0);
    check({name, "_rvalid"}, {31'd0, rvalid_o}, 32'd1);
    check(name, rdata_o, exp);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 3'd0; wdata_i = 32'd0; valid_i = 32'd0;
    cyc(); cyc();
    rst_i = 1'b0;
    check("rst_start", start_o, 32'd0);
    check("rst_done", done_o, 32'd0);
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    for (int i = 0; i < 8; i++) rd_chk(3'(i), 32'd0, "rst_read");

    // Normal transfer: valid_i 2, 6, 14, then 0
    bus(1'b1, 3'd1, 32'd3);
    bus(1'b1, 3'd2, 32'h8000_0000);
    bus(1'b1, 3'd4, 32'h8000_1000);
    check("src_lsb_prog", src_lsb_o, 32'h8000_0000);
    check("dst_lsb_prog", dst_lsb_o, 32'h8000_1000);
    bus(1'b1, 3'd0, 32'd1);
    check("launch_start", start_o, 32'd1);
    cyc(); cyc();
    check("launch_hold", start_o, 32'd1);
    valid_i = 32'd2; cyc();
    check("wait_start_low", start_o, 32'd0);
    valid_i = 32'd6; cyc();
    valid_i = 32'd14; cyc();
    check("ack_done", done_o, 32'd1);
    cyc(); cyc();
    check("ack_done_held", done_o, 32'd1);
    valid_i = 32'd0; cyc();
    check("idle_done_low", done_o, 32'd0);
    rd_chk(3'd6, 32'h0E, "status_ok");
    bus(1'b1, 3'd6, 32'h0E);
    rd_chk(3'd6, 32'h00, "status_w1c");

    // PMP denial: done without store
    bus(1'b1, 3'd0, 32'd1);
    valid_i = 32'd8; cyc();
    check("deny_done", done_o, 32'd1);
    valid_i = 32'd0; cyc();
    rd_chk(3'd6, 32'h18, "status_denied");

    // Timeout of 5 with DMA silent
    bus(1'b1, 3'd7, 32'd5);
    bus(1'b1, 3'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("to_start_hold", start_o, 32'd1);
    end
    cyc();
    check("to_ack", done_o, 32'd1);
    cyc();
    rd_chk(3'd6, 32'h28, "status_timeout");
    bus(1'b1, 3'd6, 32'h28);

    // Timeout and done on the same cycle: done wins, no TIMEOUT bit
    bus(1'b1, 3'd7, 32'd2);
    bus(1'b1, 3'd0, 32'd1);
    cyc(); cyc();
    valid_i = 32'd8; cyc();
    check("race_ack", done_o, 32'd1);
    valid_i = 32'd0; cyc();
    rd_chk(3'd6, 32'h18, "status_race");
    bus(1'b1, 3'd7, 32'd0);

    // Writes while busy are dropped and flagged
    bus(1'b1, 3'd0, 32'd1);
    valid_i = 32'd2; cyc();
    bus(1'b1, 3'd1, 32'd9);
    bus(1'b1, 3'd0, 32'd1);
    check("len_kept", length_o, 32'd3);
    rd_chk(3'd6, 32'h43, "status_busy");
    valid_i = 32'd14; cyc();
    valid_i = 32'd0; cyc();
    rd_chk(3'd6, 32'h4E, "status_wrerr");
    bus(1'b1, 3'd6, 32'h40);
    rd_chk(3'd6, 32'h0E, "status_wrerr_clr");
    rd_chk(3'd1, 32'd3, "len_read");

    // Completion interrupt
    bus(1'b1, 3'd0, 32'd3);
    valid_i = 32'd8; cyc();
    valid_i = 32'd0; cyc();
    check("irq_set", {31'd0, irq_o}, {31'd0, IRQ_BUILT});
    bus(1'b1, 3'd6, 32'h08);
    check("irq_clr", {31'd0, irq_o}, 32'd0);
    rd_chk(3'd0, {30'd0, IRQ_BUILT, 1'b0}, "ctrl_read");

    // Reset in the middle of a transfer
    bus(1'b1, 3'd0, 32'd1);
    cyc();
    rst_i = 1'b1; cyc();
    rst_i = 1'b0;
    check("midrst_start", start_o, 32'd0);
    check("midrst_done", done_o, 32'd0);
    rd_chk(3'd1, 32'd0, "midrst_len");
    rd_chk(3'd6, 32'd0, "midrst_status");
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
